constraint_sequencer: RTL and testbench

//  Frame controller and distance-constraint solver that drives the node array. Per frame it

---
 rtl/constraint_sequencer.sv | 151 +++++++++++++++
 tb/tb_constraint_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/constraint_sequencer.sv
// constraint_sequencer: per-frame Verlet strobe plus iterative distance-constraint relaxation
// over a chain of nodes, writing corrected positions back through a one-hot fix strobe.
module constraint_sequencer #(
    parameter int          N_NODES = 4,
    parameter int          ITERS   = 1,
    parameter logic [31:0] DIST    = 32'h0000a000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [32*N_NODES-1:0]  x_pos_bus,
    input  logic [32*N_NODES-1:0]  y_pos_bus,
    output logic                   verlet_state,
    output logic [N_NODES-1:0]     fix_en,
    output logic [31:0]            x_fix_constraint,
    output logic [31:0]            y_fix_constraint,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int IW = $clog2(N_NODES);
    localparam int TW = ITERS > 1 ? $clog2(ITERS) : 1;
    localparam logic [IW-1:0] LAST  = IW'(N_NODES - 1);
    localparam logic [TW-1:0] TLAST = TW'(ITERS - 1);

    typedef enum logic [3:0] {IDLE, VERLET, SETTLE, LOAD, DIV, APPLY, WRITE, NEXT, DONE} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [TW-1:0]      iter;
    logic [4:0]         cnt;
    logic signed [31:0] dx, dy, bx, by;
    logic [32:0]        l, rem;
    logic [31:0]        q;

    logic signed [31:0] xa [N_NODES];
    logic signed [31:0] ya [N_NODES];

    for (genvar i = 0; i < N_NODES; i++) begin : g_unpack
        assign xa[i] = x_pos_bus[32*i +: 32];
        assign ya[i] = y_pos_bus[32*i +: 32];
    end

    logic signed [31:0] xp, yp, ldx, ldy;
    logic [31:0]        ax, ay, mx, mn;
    logic [32:0]        len;
    logic [33:0]        trial, diff;
    logic               ge;
    logic signed [63:0] px, py;
    logic signed [31:0] fx, fy;

    // idx is the 0-based index of node k, so node k-1 sits at idx-1
    always_comb begin
        xp    = xa[idx - 1'b1];
        yp    = ya[idx - 1'b1];
        ldx   = xa[idx] - xp;
        ldy   = ya[idx] - yp;
        ax    = ldx[31] ? 32'(-ldx) : ldx;
        ay    = ldy[31] ? 32'(-ldy) : ldy;
        mx    = ax > ay ? ax : ay;
        mn    = ax > ay ? ay : ax;
        len   = {1'b0, mx} + {1'b0, mn >> 1};
        trial = {rem, q[31]};
        diff  = trial - {1'b0, l};
        ge    = trial >= {1'b0, l};
        px    = dx * $signed(q);
        py    = dy * $signed(q);
        fx    = bx + 32'(px >>> 12);
        fy    = by + 32'(py >>> 12);
    end

    // Divider starts with DIST[31:20] as remainder: L > DIST keeps the quotient within 32 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            idx              <= '0;
            iter             <= '0;
            cnt              <= '0;
            dx               <= '0;
            dy               <= '0;
            bx               <= '0;
            by               <= '0;
            l                <= '0;
            rem              <= '0;
            q                <= '0;
            verlet_state     <= 1'b0;
            fix_en           <= '0;
            x_fix_constraint <= '0;
            y_fix_constraint <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            verlet_state <= 1'b0;
            fix_en       <= '0;
            frame_done   <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    state        <= VERLET;
                    verlet_state <= 1'b1;
                    busy         <= 1'b1;
                end
                VERLET: state <= SETTLE;
                SETTLE: begin
                    idx   <= IW'(1);
                    iter  <= '0;
                    state <= LOAD;
                end
                LOAD: if (len <= {1'b0, DIST}) state <= NEXT;
                else begin
                    dx    <= ldx;
                    dy    <= ldy;
                    bx    <= xp;
                    by    <= yp;
                    l     <= len;
                    rem   <= {21'b0, DIST[31:20]};
                    q     <= {DIST[19:0], 12'b0};
                    cnt   <= '0;
                    state <= DIV;
                end
                DIV: begin
                    rem   <= 33'(ge ? diff : trial);
                    q     <= {q[30:0], ge};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? APPLY : DIV;
                end
                APPLY: begin
                    x_fix_constraint <= fx;
                    y_fix_constraint <= fy;
                    fix_en[idx]      <= 1'b1;
                    state            <= WRITE;
                end
                WRITE: state <= NEXT;
                NEXT: if (idx != LAST) begin
                    idx   <= idx + 1'b1;
                    state <= LOAD;
                end else if (iter != TLAST) begin
                    iter  <= iter + 1'b1;
                    idx   <= IW'(1);
                    state <= LOAD;
                end else begin
                    frame_done <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_constraint_sequencer.sv
// tb_constraint_sequencer: directed vectors against a 4-node rope, with a small node-array
// model that applies fix strobes so later links see corrected positions.
module tb_constraint_sequencer;
    logic         clk, reset, fs1, fs2;
    logic [127:0] xb, yb;
    logic         vs1, vs2, busy1, busy2, fd1, fd2;
    logic [3:0]   fe1, fe2;
    logic [31:0]  xf1, yf1, xf2, yf2;

    constraint_sequencer #(.N_NODES(4), .ITERS(1), .DIST(32'h0000a000)) u_dut (
        .clk(clk), .reset(reset), .frame_start(fs1), .x_pos_bus(xb), .y_pos_bus(yb),
        .verlet_state(vs1), .fix_en(fe1), .x_fix_constraint(xf1), .y_fix_constraint(yf1),
        .busy(busy1), .frame_done(fd1));

    constraint_sequencer #(.N_NODES(4), .ITERS(2), .DIST(32'h0000a000)) u_dut2 (
        .clk(clk), .reset(reset), .frame_start(fs2), .x_pos_bus(xb), .y_pos_bus(yb),
        .verlet_state(vs2), .fix_en(fe2), .x_fix_constraint(xf2), .y_fix_constraint(yf2),
        .busy(busy2), .frame_done(fd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // node array model: loads initial positions or applies fix strobes
    logic [31:0] nx [4], ny [4], ix [4], iy [4];
    logic        ld;
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (ld) begin
                nx[i] <= ix[i];
                ny[i] <= iy[i];
            end else if (fe1[i]) begin
                nx[i] <= xf1;
                ny[i] <= yf1;
            end else if (fe2[i]) begin
                nx[i] <= xf2;
                ny[i] <= yf2;
            end
    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign xb[32*i +: 32] = nx[i];
        assign yb[32*i +: 32] = ny[i];
    end

    typedef struct {
        string             name;
        logic [3:0][31:0]  x;
        logic [3:0][31:0]  y;
        int                writes;
        logic [3:0]        fe;
        logic [31:0]       fx, fy;
        int                wr_off, done_off;
    } vec_t;

    function automatic vec_t mk(string nm, logic [127:0] x, logic [127:0] y, int w,
                                logic [3:0] fe, logic [31:0] fx, logic [31:0] fy, int wo, int dn);
        vec_t v;
        v.name = nm; v.x = x; v.y = y; v.writes = w; v.fe = fe;
        v.fx = fx; v.fy = fy; v.wr_off = wo; v.done_off = dn;
        return v;
    endfunction

    int checks = 0, errors = 0;
    int vs_c, wr_c, done_c, nwr;
    logic [3:0]  last_fe;
    logic [31:0] last_fx, last_fy;
    vec_t tv [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ix[i] = v.x[i];
            iy[i] = v.y[i];
        end
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // pulse frame_start on one DUT and record event cycles; pulse_at re-pulses mid-frame
    task automatic run(input bit sel, input int pulse_at);
        int c;
        c = 0; vs_c = -1; wr_c = -1; done_c = -1; nwr = 0;
        last_fe = '0; last_fx = '0; last_fy = '0;
        @(negedge clk);
        if (sel) fs2 = 1'b1; else fs1 = 1'b1;
        while (done_c < 0 && c < 300) begin
            @(negedge clk);
            c++;
            fs1 = (!sel && c == pulse_at);
            fs2 = (sel && c == pulse_at);
            if ((sel ? vs2 : vs1) && vs_c < 0) vs_c = c;
            if ((sel ? fe2 : fe1) != 4'b0) begin
                nwr++;
                last_fe = sel ? fe2 : fe1;
                last_fx = sel ? xf2 : xf1;
                last_fy = sel ? yf2 : yf1;
                wr_c = c;
            end
            if (sel ? fd2 : fd1) done_c = c;
        end
        fs1 = 1'b0;
        fs2 = 1'b0;
    endtask

    task automatic check_run(input vec_t v);
        chk({v.name, " verlet latency"}, 32'(vs_c), 32'd1);
        chk({v.name, " frame_done offset"}, 32'(done_c - vs_c), 32'(v.done_off));
        chk({v.name, " write count"}, 32'(nwr), 32'(v.writes));
        if (v.writes > 0) begin
            chk({v.name, " fix_en"}, 32'(last_fe), 32'(v.fe));
            chk({v.name, " x_fix"}, last_fx, v.fx);
            chk({v.name, " y_fix"}, last_fy, v.fy);
            chk({v.name, " write offset"}, 32'(wr_c - vs_c), 32'(v.wr_off));
        end
    endtask

    initial begin
        int n;
        tv[0] = mk("rest", {4{32'hc8000}}, {32'h1e000, 32'h14000, 32'h0a000, 32'h0},
                   0, 4'b0, 0, 0, 0, 8);
        tv[1] = mk("stretch_y", {4{32'hc8000}}, {32'h1e000, 32'h14000, 32'h14000, 32'h0},
                   1, 4'b0010, 32'hc8000, 32'h0a000, 36, 42);
        tv[2] = mk("diagonal", {32'hceaa4, 32'hceaa4, 32'hdc000, 32'hc8000},
                   {32'h1aaa4, 32'h10aa4, 32'h14000, 32'h0},
                   1, 4'b0010, 32'hceaa4, 32'h06aa4, 36, 42);
        tv[3] = mk("neg_dx", {32'haa000, 32'hb4000, 32'hb4000, 32'hc8000}, 128'h0,
                   1, 4'b0010, 32'hbe000, 32'h0, 36, 42);
        tv[4] = mk("last_link", 128'h0, {32'h28000, 32'h14000, 32'h0a000, 32'h0},
                   1, 4'b1000, 32'h0, 32'h1e000, 40, 42);
        tv[5] = mk("chain3", 128'h0, {32'h32000, 32'h28000, 32'h14000, 32'h0},
                   3, 4'b1000, 32'h0, 32'h1dfef, 108, 110);

        reset = 1'b0; fs1 = 1'b1; fs2 = 1'b1; ld = 1'b0;
        for (int i = 0; i < 4; i++) begin ix[i] = '0; iy[i] = '0; end
        repeat (3) @(negedge clk);
        chk("reset busy", 32'({busy1, busy2}), 32'd0);
        chk("reset outputs", 32'({vs1, fe1, fd1, vs2, fe2, fd2}), 32'd0);
        chk("reset fix data", xf1 | yf1 | xf2 | yf2, 32'd0);
        fs1 = 1'b0; fs2 = 1'b0; reset = 1'b1;

        for (int t = 0; t < 6; t++) begin
            load(tv[t]);
            run(1'b0, 0);
            check_run(tv[t]);
        end

        // two relaxation passes: second pass finds every link at rest
        load(tv[3]);
        run(1'b1, 0);
        chk("iters2 write count", 32'(nwr), 32'd1);
        chk("iters2 x_fix", last_fx, 32'hbe000);
        chk("iters2 frame_done offset", 32'(done_c - vs_c), 32'd48);

        // frame_start while dividing must be dropped, not queued
        load(tv[1]);
        run(1'b0, 12);
        check_run(tv[1]);
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (fd1 || vs1) n++;
        end
        chk("ignored start extra events", 32'(n), 32'd0);
        chk("ignored start busy", 32'(busy1), 32'd0);

        // async reset in the middle of a divide
        load(tv[1]);
        @(negedge clk); fs1 = 1'b1;
        @(negedge clk); fs1 = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (fe1 != 4'b0) n++;
        end
        chk("pre-abort busy", 32'(busy1), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort outputs", 32'({vs1, fe1, fd1}), 32'd0);
        chk("abort fix data", xf1 | yf1, 32'd0);
        chk("abort writes", 32'(n), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        load(tv[1]);
        run(1'b0, 0);
        check_run(tv[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
